// File: rtl/moore_pattern_pkg.sv
// Shared types and constants for the serial pattern generator.
// The canonical constant is the stimulus the Moore sequence detector is tested with.
package moore_pattern_pkg;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN) + 1;

  localparam logic [7:0] DET_PATTERN = 8'b01010011;
  localparam int         DET_LEN     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // A length is usable only if it selects at least one bit and fits the pattern field.
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// Parallel-load shift register: the valid field is packed against the MSB so the
// serial output always comes from the top bit, whatever the pattern length.
module pattern_shift_reg
  import moore_pattern_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               msb
);

  logic [MAX_LEN-1:0] masked;
  logic [MAX_LEN-1:0] aligned;
  logic [MAX_LEN-1:0] shreg_reg;
  logic [LEN_W-1:0]   pad;

  // Bits above the valid field are dropped so they cannot leak in during the shift-up.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign masked[gi] = pat[gi] & (LEN_W'(gi) < len);
    end
  endgenerate

  assign pad     = LEN_W'(MAX_LEN) - len;
  assign aligned = masked << pad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg <= '0;
    end else if (clr) begin
      shreg_reg <= '0;
    end else if (load) begin
      shreg_reg <= aligned;
    end else if (shift) begin
      shreg_reg <= {shreg_reg[MAX_LEN-2:0], 1'b0};
    end
  end

  assign msb = shreg_reg[MAX_LEN-1];

endmodule

// File: rtl/moore_pattern_gen.sv
// Serial pattern generator: Moore FSM that shifts a captured pattern out MSB-first,
// optionally repeating it with an idle gap, and pulses done after the final frame.
module moore_pattern_gen
  import moore_pattern_pkg::*;
#(
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int LEN_W      = $clog2(MAX_LEN) + 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic [3:0]         rep_in,
  input  logic               abort,
  output logic               outbit,
  output logic               bit_valid,
  output logic               busy,
  output logic               done
);

  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   idx_reg, idx_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic [3:0]         rep_reg, rep_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [MAX_LEN-1:0] pat_reg, pat_next;

  logic               sr_clr;
  logic               sr_load;
  logic               sr_shift;
  logic [MAX_LEN-1:0] sr_pat;
  logic [LEN_W-1:0]   sr_len;
  logic               sr_msb;

  logic start_ok;
  logic last_bit;

  assign start_ok = start && !abort && len_legal(32'(len_in), MAX_LEN);
  assign last_bit = (idx_reg == len_reg - LEN_W'(1));

  pattern_shift_reg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sr_clr),
    .load  (sr_load),
    .shift (sr_shift),
    .pat   (sr_pat),
    .len   (sr_len),
    .msb   (sr_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      gap_reg   <= '0;
      rep_reg   <= '0;
      len_reg   <= '0;
      pat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      gap_reg   <= gap_next;
      rep_reg   <= rep_next;
      len_reg   <= len_next;
      pat_reg   <= pat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    gap_next   = gap_reg;
    rep_next   = rep_reg;
    len_next   = len_reg;
    pat_next   = pat_reg;
    sr_clr     = 1'b0;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    sr_pat     = pat_reg;
    sr_len     = len_reg;

    case (state_reg)
      ST_IDLE: begin
        // Loading straight from the inputs puts bit 0 on the line in the first SEND cycle.
        if (start_ok) begin
          state_next = ST_SEND;
          idx_next   = '0;
          gap_next   = '0;
          rep_next   = rep_in;
          len_next   = len_in;
          pat_next   = pat_in;
          sr_load    = 1'b1;
          sr_pat     = pat_in;
          sr_len     = len_in;
        end
      end

      ST_SEND: begin
        if (abort) begin
          state_next = ST_IDLE;
          sr_clr     = 1'b1;
        end else if (last_bit) begin
          idx_next = '0;
          if (rep_reg != 4'd0) begin
            rep_next = rep_reg - 4'd1;
            sr_load  = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_next = ST_GAP;
              gap_next   = '0;
            end
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          idx_next = idx_reg + LEN_W'(1);
          sr_shift = 1'b1;
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_next = ST_IDLE;
          sr_clr     = 1'b1;
        end else if (gap_reg == GAP_W'(GAP_LAST)) begin
          state_next = ST_SEND;
          idx_next   = '0;
          gap_next   = '0;
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
        sr_clr     = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
        sr_clr     = 1'b1;
      end
    endcase

    // Leaving a transmission by any route scrubs all per-transfer context.
    if (state_reg != ST_IDLE && state_next == ST_IDLE) begin
      idx_next = '0;
      gap_next = '0;
      rep_next = '0;
      len_next = '0;
      pat_next = '0;
    end
  end

  always_comb begin
    outbit    = 1'b0;
    bit_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_reg)
      ST_SEND: begin
        outbit    = sr_msb;
        bit_valid = 1'b1;
        busy      = 1'b1;
      end
      ST_GAP: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        outbit = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_moore_pattern_gen.sv
// Directed bench for moore_pattern_gen: a frame-level model predicts every output
// cycle, and literal expectations pin the bit streams and busy/done counts.
module tb_moore_pattern_gen;
  import moore_pattern_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int GAP     = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [MAX_LEN-1:0] pat_in = '0;
  logic [LEN_W-1:0]   len_in = '0;
  logic [3:0]         rep_in = '0;
  logic               abort = 1'b0;
  logic               outbit, bit_valid, busy, done;

  moore_pattern_gen #(
    .MAX_LEN    (MAX_LEN),
    .LEN_W      (LEN_W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pat_in    (pat_in),
    .len_in    (len_in),
    .rep_in    (rep_in),
    .abort     (abort),
    .outbit    (outbit),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: each accepted start expands into the full per-cycle output schedule.
  typedef struct packed {
    logic ob;
    logic bv;
    logic dn;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      if (abort) exp_q.delete();
      else void'(exp_q.pop_front());
    end else if (start && !abort && len_in >= 1 && int'(len_in) <= MAX_LEN) begin
      for (int f = 0; f <= int'(rep_in); f++) begin
        for (int i = 0; i < int'(len_in); i++)
          exp_q.push_back('{ob: pat_in[int'(len_in) - 1 - i], bv: 1'b1, dn: 1'b0});
        if (f < int'(rep_in))
          for (int g = 0; g < GAP; g++) exp_q.push_back('{ob: 1'b0, bv: 1'b0, dn: 1'b0});
      end
      exp_q.push_back('{ob: 1'b0, bv: 1'b0, dn: 1'b1});
    end
  end

  always @(negedge rst_n) exp_q.delete();

  // Per-cycle comparison plus stream/count recording for the literal checks.
  logic [31:0] rec_bits = '0;
  int rec_n = 0, busy_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() == 0) e = 4'b0000;
    else e = {exp_q[0].ob, exp_q[0].bv, 1'b1, exp_q[0].dn};
    check("cycle {outbit,bit_valid,busy,done}", 32'({outbit, bit_valid, busy, done}), 32'(e));
    if (bit_valid) begin
      rec_bits <= {rec_bits[30:0], outbit};
      rec_n    <= rec_n + 1;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    @(negedge clk);
    rec_bits = '0;
    rec_n    = 0;
    busy_cnt = 0;
    done_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic [3:0] r);
    pat_in = p;
    len_in = l;
    rep_in = r;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    check("reset outputs", 32'({outbit, bit_valid, busy, done}), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: canonical detector pattern, single frame
    clear_rec();
    $display("txn 1: pat=%b len=%0d rep=0", DET_PATTERN, DET_LEN);
    send(MAX_LEN'(DET_PATTERN), LEN_W'(DET_LEN), 4'd0);
    wait_idle("t1 idle timeout");
    check("t1 bit count", 32'(rec_n), 32'd8);
    check("t1 stream", {24'd0, rec_bits[7:0]}, 32'h53);
    check("t1 busy cycles", 32'(busy_cnt), 32'd9);
    check("t1 done pulses", 32'(done_cnt), 32'd1);

    // 2: 3-bit pattern, two extra repeats with gaps
    clear_rec();
    $display("txn 2: pat=101 len=3 rep=2");
    send(16'b101, LEN_W'(3), 4'd2);
    wait_idle("t2 idle timeout");
    check("t2 stream", {23'd0, rec_bits[8:0]}, 32'b101101101);
    check("t2 busy cycles", 32'(busy_cnt), 32'd14);
    check("t2 done pulses", 32'(done_cnt), 32'd1);

    // 3: illegal lengths are ignored
    clear_rec();
    $display("txn 3: start with len=0 and len=%0d", MAX_LEN + 1);
    send(16'hFFFF, LEN_W'(0), 4'd0);
    send(16'hFFFF, LEN_W'(MAX_LEN + 1), 4'd0);
    repeat (2) tick();
    check("t3 busy cycles", 32'(busy_cnt), 32'd0);
    check("t3 valid bits", 32'(rec_n), 32'd0);

    // 4: full-length frame with a stray start mid-frame, then length 1
    clear_rec();
    $display("txn 4: all-ones len=%0d with mid-frame start, then len=1", MAX_LEN);
    send(16'hFFFF, LEN_W'(MAX_LEN), 4'd0);
    repeat (4) tick();
    send(16'h0000, LEN_W'(4), 4'd3);
    wait_idle("t4a idle timeout");
    send(16'h0001, LEN_W'(1), 4'd0);
    wait_idle("t4b idle timeout");
    check("t4 bit count", 32'(rec_n), 32'd17);
    check("t4 stream", {15'd0, rec_bits[16:0]}, 32'h1FFFF);
    check("t4 done pulses", 32'(done_cnt), 32'd2);

    // 5: abort on the 4th bit, then immediate restart
    clear_rec();
    $display("txn 5: abort on bit 4 of %b, then restart", DET_PATTERN);
    send(MAX_LEN'(DET_PATTERN), LEN_W'(DET_LEN), 4'd0);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5 busy after abort", 32'(busy), 32'd0);
    check("t5 bits before abort", {28'd0, rec_bits[3:0]}, 32'b0101);
    check("t5 count before abort", 32'(rec_n), 32'd4);
    send(16'b101, LEN_W'(3), 4'd0);
    wait_idle("t5 idle timeout");
    check("t5 restart stream", {29'd0, rec_bits[2:0]}, 32'b101);
    check("t5 done pulses", 32'(done_cnt), 32'd1);

    // 6: reset during the gap, then a fresh frame
    $display("txn 6: reset mid-gap, then pat=%b", DET_PATTERN);
    send(16'b110, LEN_W'(3), 4'd1);
    repeat (3) tick();
    check("t6 in gap", 32'({bit_valid, busy}), 32'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async reset outputs", 32'({outbit, bit_valid, busy, done}), 32'd0);
    tick();
    rst_n = 1'b1;
    clear_rec();
    send(MAX_LEN'(DET_PATTERN), LEN_W'(DET_LEN), 4'd0);
    wait_idle("t6 idle timeout");
    check("t6 stream", {24'd0, rec_bits[7:0]}, 32'h53);
    check("t6 busy cycles", 32'(busy_cnt), 32'd9);

    tick();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/moore_pattern_gen.md
# moore_pattern_gen

Serial pattern generator: transmit side of the Moore sequence-detector path. It shifts a loaded bit pattern onto a single serial line, one bit per clock. It can repeat the frame a programmed number of times with an idle gap between repeats. It drives the detector's `inbit` input in system-level checks, so detector stimulus comes from hardware rather than hand-timed bench writes.

## Interface
Parameters:
- MAX_LEN, 16, maximum pattern length in bits (≥ 2)
- LEN_W, $clog2(MAX_LEN)+1, width of length field
- GAP_CYCLES, 2, idle cycles between repeated frames (0 allowed)

Ports:
- Clock `clk`, single clock domain; reset `rst_n`, asynchronous, active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a transmission; sampled in IDLE only
- pat_in  in  MAX_LEN  pattern; bits [len_in-1:0] valid
- len_in  in  LEN_W  pattern length, legal 1..MAX_LEN
- rep_in  in  4  extra repeats after the first frame (0 = send once)
- abort  in  1  terminate transmission, return to IDLE
- outbit  out  1  serial data bit
- bit_valid  out  1  high while outbit carries a pattern bit
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse after final bit of final frame

## Operation
- Moore FSM; all outputs decoded from registered state/datapath only, never from inputs.
- States: IDLE, SEND, GAP, DONE.
- IDLE: outbit=0, bit_valid=0, busy=0, done=0.
  - start=1 with 1 ≤ len_in ≤ MAX_LEN: capture pat_in, len_in, rep_in; load shift register; go to SEND.
  - start with len_in=0 or len_in>MAX_LEN: ignored; stay in IDLE.
- SEND:
  - bit_valid=1, busy=1; outbit = pattern bit [len-1-idx], i.e. MSB of valid field first.
  - Bit index increments each cycle.
  - After bit index len-1:
    - if repeat counter > 0 and GAP_CYCLES > 0: go to GAP.
    - if repeat counter > 0 and GAP_CYCLES = 0: reload and stay in SEND, giving back-to-back frames.
    - if repeat counter = 0: go to DONE.
    - The repeat counter decrements and the shift register reloads from the captured pattern on each repeat.
- GAP: outbit=0, bit_valid=0, busy=1; hold for exactly GAP_CYCLES cycles, then SEND with idx=0.
- DONE: done=1, busy=1, bit_valid=0 for one cycle, then IDLE.
- Ignored inputs:
  - start outside IDLE: ignored; the captured pattern is not disturbed.
  - pat_in, len_in and rep_in changes after capture: no effect.
- abort=1 in SEND, GAP or DONE: next state IDLE; done not pulsed; counters cleared. abort in IDLE: no effect. abort and start together in IDLE: abort wins, start is ignored.
- Reset (rst_n low, any time, including mid-frame): state=IDLE; outbit=0, bit_valid=0, busy=0, done=0; counters and shift register cleared.

## Timing
- start sampled high at edge k: SEND entered at edge k, and bit 0 is on outbit from edge k to edge k+1.
- Each bit is held exactly one clock.
- Frame duration: len cycles.
- Total busy cycles = (rep+1)·len + rep·GAP_CYCLES + 1.
- done is high for the single cycle following the last bit.
- Minimum start-to-start period (rep=0): len+2 cycles, because start is accepted only in IDLE.
- abort sampled at edge m: outputs show IDLE values from edge m.
- Reset assertion takes effect immediately (async). Deassertion is synchronous to design; first start is accepted at the first rising edge with rst_n high.

## Structure
- Package `moore_pattern_pkg`:
  - state enum (IDLE, SEND, GAP, DONE)
  - MAX_LEN/LEN_W defaults
  - the canonical detector test pattern constant: 8'b01010011, len 8.
- Sub-module `pattern_shift_reg`:
  - parallel load of MAX_LEN bits, MSB-aligned by length.
  - shift-left enable.
  - serial MSB output.
- The top module holds the FSM, bit index counter, gap counter and repeat counter.

## Test plan
- pat_in=8'b01010011, len_in=8, rep_in=0, start one cycle → outbit sequence 0,1,0,1,0,0,1,1 with bit_valid high for 8 cycles. Then done pulses once and busy drops after 9 cycles.
- pat_in=3'b101, len_in=3, rep_in=2, GAP_CYCLES=2 → 1,0,1, gap 0,0, 1,0,1, gap 0,0, 1,0,1, done. busy high for 14 cycles.
- len_in=0 with start, and len_in=MAX_LEN+1 with start → no state change; busy, bit_valid and done remain 0.
- len_in=MAX_LEN, all-ones pattern, then len_in=1, pattern 1 → 16 ones then a single 1. start asserted mid-frame is ignored and does not alter the output.
- abort asserted on the 4th bit of an 8-bit frame → IDLE outputs from that edge, and no done pulse. A new start is accepted on the next cycle.
- rst_n pulsed low mid-GAP → all outputs 0 immediately. After release, a fresh frame is transmitted correctly from bit 0.
